// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: time-multiplexed 7-segment driver for a packed BCD word.
// Words arrive on a valid/ready handshake into a one-entry pending buffer
// and are committed to the display register only at frame starts. Each digit
// slot is a dead-time BLANK phase followed by a DRIVE phase.
// Optional feature macro: BCD_SEG_LZB_EN (leading-zero blanking).
module bcd_seg_scan #(
  parameter int NUM_DIGITS     = 3,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    bcd_valid,
  output logic                    bcd_ready,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick,
  output logic                    bcd_err
);

  localparam int MAX_COUNT = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW        = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam int IW        = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0]         BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0]         DRIVE_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t                  state, state_n;
  logic [IW-1:0]           idx, idx_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic                    started;
  logic [4*NUM_DIGITS-1:0] pend_word;
  logic                    pend_full, pend_full_n;
  logic [4*NUM_DIGITS-1:0] disp, disp_n;
  logic                    frame_start;
  logic                    accept, commit;
  logic [3:0]              cur_nib;
  logic                    digit_blank;
  logic                    err_n;
  logic [6:0]              seg_hi, seg_n;
  logic [NUM_DIGITS-1:0]   an_hi, an_n;

  // Active-high segment pattern for one BCD digit; A-F light nothing.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] p;
    p = 7'h00;
    case (d)
      4'd0: p = 7'h3F;
      4'd1: p = 7'h06;
      4'd2: p = 7'h5B;
      4'd3: p = 7'h4F;
      4'd4: p = 7'h66;
      4'd5: p = 7'h6D;
      4'd6: p = 7'h7D;
      4'd7: p = 7'h07;
      4'd8: p = 7'h7F;
      4'd9: p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  // Next scan position; the first edge after reset lands on the frame start.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    if (!started) begin
      state_n = BLANK;
      idx_n   = '0;
      cnt_n   = '0;
    end else if (state == BLANK) begin
      if (cnt == BLANK_LAST) begin
        state_n = DRIVE;
        cnt_n   = '0;
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end else begin
      if (cnt == DRIVE_LAST) begin
        state_n = BLANK;
        cnt_n   = '0;
        idx_n   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end
    frame_start = (state_n == BLANK) && (idx_n == '0) && (cnt_n == '0);
  end

  // Handshake and frame-boundary commit of the pending word.
  always_comb begin
    accept      = bcd_valid && bcd_ready;
    commit      = frame_start && pend_full;
    disp_n      = commit ? pend_word : disp;
    pend_full_n = pend_full;
    if (accept) begin
      pend_full_n = 1'b1;
    end else if (commit) begin
      pend_full_n = 1'b0;
    end
  end

  // Digit selection, optional leading-zero blanking and error flag.
  always_comb begin
    cur_nib     = disp_n[idx_n*4 +: 4];
    err_n       = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (disp_n[k*4 +: 4] > 4'd9) begin
        err_n = 1'b1;
      end
    end
`ifdef BCD_SEG_LZB_EN
    begin : lzb
      logic [NUM_DIGITS-1:0] upper_zero;
      upper_zero = '0;
      upper_zero[NUM_DIGITS-1] = (disp_n[4*NUM_DIGITS-1 -: 4] == 4'd0);
      for (int k = NUM_DIGITS - 2; k >= 1; k--) begin
        upper_zero[k] = upper_zero[k+1] && (disp_n[k*4 +: 4] == 4'd0);
      end
      upper_zero[0] = 1'b0;
      digit_blank = upper_zero[idx_n];
    end
`else
    digit_blank = 1'b0;
`endif
  end

  // Output patterns for the state being entered, polarity applied last.
  always_comb begin
    seg_hi = 7'h00;
    an_hi  = '0;
    if ((state_n == DRIVE) && !digit_blank) begin
      seg_hi = decode(cur_nib);
      an_hi  = NUM_DIGITS'(1) << idx_n;
    end
    seg_n = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
    an_n  = AN_ACTIVE_LOW ? ~an_hi : an_hi;
  end

  // Scan FSM with all state and outputs registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BLANK;
      idx        <= '0;
      cnt        <= '0;
      started    <= 1'b0;
      pend_word  <= '0;
      pend_full  <= 1'b0;
      disp       <= '0;
      seg        <= SEG_OFF;
      an         <= AN_OFF;
      frame_tick <= 1'b0;
      bcd_ready  <= 1'b0;
      bcd_err    <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      started    <= 1'b1;
      if (accept) begin
        pend_word <= bcd_in;
      end
      pend_full  <= pend_full_n;
      disp       <= disp_n;
      seg        <= seg_n;
      an         <= an_n;
      frame_tick <= frame_start;
      bcd_ready  <= ~pend_full_n;
      bcd_err    <= err_n;
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// tb_bcd_seg_scan: directed self-checking bench for bcd_seg_scan with a
// short scan (3 digits, 1 blank cycle, 4 drive cycles, active-low outputs).
module tb_bcd_seg_scan;

  logic        clk;
  logic        rst;
  logic [11:0] bcd_in;
  logic        bcd_valid;
  logic        bcd_ready;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic        frame_tick;
  logic        bcd_err;

  int checks = 0;
  int errors = 0;

  bcd_seg_scan #(
    .NUM_DIGITS    (3),
    .REFRESH_DIV   (4),
    .BLANK_CYCLES  (1),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bcd_in    (bcd_in),
    .bcd_valid (bcd_valid),
    .bcd_ready (bcd_ready),
    .seg       (seg),
    .an        (an),
    .frame_tick(frame_tick),
    .bcd_err   (bcd_err)
  );

  // 10-unit clock period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [11:0] observed, input logic [11:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one clock and land on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One-cycle offer of a word; caller ensures ready is high.
  task automatic applyStimulus(input logic [11:0] word);
    bcd_in    = word;
    bcd_valid = 1'b1;
    step();
    bcd_valid = 1'b0;
  endtask

  // Step until frame_tick is seen, bounded.
  task automatic waitTick(input string tag);
    int n;
    n = 0;
    step();
    while (frame_tick !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checkOutput(tag, {11'd0, frame_tick}, 12'd1);
  endtask

  // Checks a whole frame starting at the frame_tick cycle.
  task automatic checkFrame(input string tag,
                            input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                            input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2);
    logic [6:0] s [3];
    logic [2:0] a [3];
    s[0] = s0; s[1] = s1; s[2] = s2;
    a[0] = a0; a[1] = a1; a[2] = a2;
    for (int d = 0; d < 3; d++) begin
      if (d != 0) step();
      checkOutput({tag, "_blank_an"}, {9'd0, an}, 12'h007);
      checkOutput({tag, "_blank_seg"}, {5'd0, seg}, 12'h07F);
      for (int r = 0; r < 4; r++) begin
        step();
        checkOutput({tag, "_drive_an"}, {9'd0, an}, {9'd0, a[d]});
        checkOutput({tag, "_drive_seg"}, {5'd0, seg}, {5'd0, s[d]});
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    bcd_in    = 12'h000;
    bcd_valid = 1'b0;

    // Reset held three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_seg", {5'd0, seg}, 12'h07F);
      checkOutput("rst_an", {9'd0, an}, 12'h007);
      checkOutput("rst_ready", {11'd0, bcd_ready}, 12'd0);
      checkOutput("rst_tick", {11'd0, frame_tick}, 12'd0);
      checkOutput("rst_err", {11'd0, bcd_err}, 12'd0);
    end
    rst = 1'b0;
    #1;
    checkOutput("rel_ready_low", {11'd0, bcd_ready}, 12'd0);
    step();
    checkOutput("first_tick", {11'd0, frame_tick}, 12'd1);
    checkOutput("first_ready", {11'd0, bcd_ready}, 12'd1);
    checkOutput("first_an", {9'd0, an}, 12'h007);

    // Single-cycle offer of 127, shown from the next frame.
    applyStimulus(12'h127);
    checkOutput("acc_ready_low", {11'd0, bcd_ready}, 12'd0);
    checkOutput("acc_still_zero_an", {9'd0, an}, 12'h006);
    checkOutput("acc_still_zero_seg", {5'd0, seg}, 12'h040);
    waitTick("tick_127");
    checkOutput("commit_ready", {11'd0, bcd_ready}, 12'd1);
    checkOutput("commit_err", {11'd0, bcd_err}, 12'd0);
    checkFrame("f127", 7'h78, 7'h24, 7'h79, 3'b110, 3'b101, 3'b011);

    // Valid held: 127 captured, 358 must wait for the next commit.
    bcd_in    = 12'h127;
    bcd_valid = 1'b1;
    step();
    checkOutput("hold_tick", {11'd0, frame_tick}, 12'd1);
    checkOutput("hold_ready", {11'd0, bcd_ready}, 12'd0);
    bcd_in = 12'h358;
    step();
    checkOutput("hold_ready2", {11'd0, bcd_ready}, 12'd0);
    waitTick("tick_hold");
    checkOutput("hold_ready_back", {11'd0, bcd_ready}, 12'd1);
    step();
    bcd_valid = 1'b0;
    checkOutput("acc358_ready", {11'd0, bcd_ready}, 12'd0);
    checkOutput("f127b_d0_an", {9'd0, an}, 12'h006);
    checkOutput("f127b_d0_seg", {5'd0, seg}, 12'h078);
    for (int i = 0; i < 10; i++) step();
    checkOutput("f127b_d2_an", {9'd0, an}, 12'h003);
    checkOutput("f127b_d2_seg", {5'd0, seg}, 12'h079);
    waitTick("tick_358");
    checkOutput("ready_358", {11'd0, bcd_ready}, 12'd1);
    checkFrame("f358", 7'h00, 7'h12, 7'h30, 3'b110, 3'b101, 3'b011);

    // Invalid nibble in the middle digit.
    applyStimulus(12'h1A3);
    waitTick("tick_1a3");
    checkOutput("err_1a3", {11'd0, bcd_err}, 12'd1);
    checkFrame("f1a3", 7'h30, 7'h7F, 7'h79, 3'b110, 3'b101, 3'b011);
    applyStimulus(12'h123);
    checkOutput("err_pending", {11'd0, bcd_err}, 12'd1);
    waitTick("tick_123");
    checkOutput("err_clear", {11'd0, bcd_err}, 12'd0);
    checkFrame("f123", 7'h30, 7'h24, 7'h79, 3'b110, 3'b101, 3'b011);

    // Leading zeros.
    applyStimulus(12'h007);
    waitTick("tick_007");
`ifdef BCD_SEG_LZB_EN
    checkFrame("f007", 7'h78, 7'h7F, 7'h7F, 3'b110, 3'b111, 3'b111);
`else
    checkFrame("f007", 7'h78, 7'h40, 7'h40, 3'b110, 3'b101, 3'b011);
`endif

    // Reset in the middle of digit 1 DRIVE.
    waitTick("tick_pre_rst");
    for (int i = 0; i < 7; i++) step();
`ifdef BCD_SEG_LZB_EN
    checkOutput("mid_d1_an", {9'd0, an}, 12'h007);
`else
    checkOutput("mid_d1_an", {9'd0, an}, 12'h005);
    checkOutput("mid_d1_seg", {5'd0, seg}, 12'h040);
`endif
    #2 rst = 1'b1;
    #1;
    checkOutput("async_an", {9'd0, an}, 12'h007);
    checkOutput("async_seg", {5'd0, seg}, 12'h07F);
    checkOutput("async_ready", {11'd0, bcd_ready}, 12'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    checkOutput("rerst_tick", {11'd0, frame_tick}, 12'd1);
    checkOutput("rerst_err", {11'd0, bcd_err}, 12'd0);
    step();
    checkOutput("rerst_d0_an", {9'd0, an}, 12'h006);
    checkOutput("rerst_d0_seg", {5'd0, seg}, 12'h040);
    for (int i = 0; i < 5; i++) step();
`ifdef BCD_SEG_LZB_EN
    checkOutput("rerst_d1_an", {9'd0, an}, 12'h007);
`else
    checkOutput("rerst_d1_an", {9'd0, an}, 12'h005);
    checkOutput("rerst_d1_seg", {5'd0, seg}, 12'h040);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
